bsg_piso_rr_scheduler: RTL
==========================

// Module: bsg_piso_rr_scheduler
// PURPOSE
// - Shares one parallel-in/serial-out serializer among num_req_p requesters.
// - Each requester offers an els_p x width_p word. A round-robin arbiter grants one word at a time.
// - The granted word is latched and emitted one element per beat on a valid-then-yumi channel.
// - Each beat carries the source id and a last-beat flag.
// - Sits between per-lane packet producers and a single narrow link/FIFO.
// PARAMETERS
// - num_req_p  default 3  number of requesters (>=2)
// - width_p    default 16 bits per serial element
// - els_p      default 4  elements per parallel word (>=2)
// - hi_to_lo_p default 0  0: emit element 0 first; 1: emit element els_p-1 first
// PORTS
// - clk_i        in  1                          single clock
// - reset_i      in  1                          reset, asynchronous, active-high
// - valid_i      in  num_req_p                  per-requester word valid
// - data_i       in  num_req_p*els_p*width_p    per-requester parallel word, [req][el][bit]
// - ready_and_o  in/out: out  num_req_p         one-hot accept, at most one bit set
// - valid_o      out 1                          serial element valid
// - data_o       out width_p                    serial element
// - tag_o        out max(1,$clog2(num_req_p))   source requester id of current word
// - last_o       out 1                          current beat is final element of word
// - yumi_i       in  1                          consumer takes beat; legal only when valid_o=1
// BEHAVIOUR
// - Reset (async assert, sync release) clears all state:
//   - state=IDLE, rr_ptr_r=0, shift_ctr_r=0
//   - valid_o=0, last_o=0, tag_o=0, data_o=0, ready_and_o from IDLE rule only
// - Two states:
//   - IDLE: no word held.
//   - SHIFT: a word is held and beats are pending.
// - Grant (combinational):
//   - gnt = first i with valid_i[i]=1, scanning rr_ptr_r, rr_ptr_r+1, ... modulo num_req_p.
//   - gnt is all-zero when no valid_i bit is set.
// - ready_and_o = gnt & {num_req_p{ IDLE | (SHIFT & last_o & yumi_i) }}.
//   - ready depends on valid_i and yumi_i. Producers must not wait on ready before raising valid.
// - Accept is valid_i[i] & ready_and_o[i]. On accept:
//   - latch data_i[i]; tag_r=i; rr_ptr_r=(i+1) mod num_req_p; shift_ctr_r=0; state=SHIFT.
// - Latency: word accepted in cycle t gives valid_o=1 with its first element in cycle t+1.
//   - No combinational path from data_i to data_o.
// - In SHIFT:
//   - valid_o=1.
//   - data_o = latched element shift_ctr_r, or element els_p-1-shift_ctr_r when hi_to_lo_p=1.
//   - last_o = (shift_ctr_r==els_p-1).
// - data_o, tag_o and last_o stay stable while valid_o=1 and yumi_i=0. Holding indefinitely is legal.
// - yumi_i & !last_o: shift_ctr_r++.
// - yumi_i & last_o with a new accept in the same cycle: reload as above, stay in SHIFT, no bubble.
// - yumi_i & last_o with no accept: state=IDLE, valid_o=0 next cycle.
// - rr_ptr_r changes only on accept. Idle cycles and stalls do not advance it.
// - A requester that drops valid_i before being granted loses nothing. No request state is stored.
// - shift_ctr_r width is $clog2(els_p) and never exceeds els_p-1.
//   - Wrap happens only via reload or IDLE, never by natural overflow.
// - Reset mid-word: the word in progress is discarded and no beat is emitted after release.
// - Assertions, simulation only:
//   - yumi_i must not be 1 while valid_o=0.
//   - ready_and_o must be one-hot or zero.
// CONFIGURATION
// - Macro BSG_PISO_RR_SCHED_PERF_CTR_EN.
// - Defined: adds output stall_cnt_o, 32 bits, saturating.
//   - Counts cycles with valid_o=1 & yumi_i=0.
//   - Cleared by reset_i.
// - Undefined: port and counter are absent. All other behaviour is identical.
// TESTING (num_req_p=3, els_p=4, width_p=16)
// - Single word:
//   - Stimulus: only req1 valid, data {0x0004,0x0003,0x0002,0x0001} (el3..el0), yumi_i=1.
//   - Response: beats 0x0001,0x0002,0x0003,0x0004; tag_o=1; last_o only on 4th beat; rr_ptr_r=2.
// - Fairness:
//   - Stimulus: all three requesters valid continuously from reset.
//   - Response: grant order 0,1,2,0,1,2; 24 back-to-back beats, no bubble between words.
// - Backpressure:
//   - Stimulus: yumi_i low for 5 cycles mid-word.
//   - Response: data_o, tag_o, last_o hold; no element skipped or repeated.
//   - With the macro defined: stall_cnt_o=5.
// - hi_to_lo_p=1:
//   - Stimulus: same word as the single-word test.
//   - Response: 0x0004,0x0003,0x0002,0x0001.
// - Reset after beat 2 of a word:
//   - Response: valid_o=0 at once, rr_ptr_r=0.
//   - The next accepted word starts at its first element.
// - Late request:
//   - Stimulus: req2 raises valid_i in the last_o&yumi_i cycle of req0's word; req1 idle.
//   - Response: req2 accepted that cycle; tag_o=2 on the next beat.

Source files
------------

// File: rtl/bsg_piso_rr_scheduler.sv
// Round-robin arbitrated parallel-in/serial-out serializer shared by num_req_p requesters.
// Define BSG_PISO_RR_SCHED_PERF_CTR_EN to add the saturating stall_cnt_o performance counter.
module bsg_piso_rr_scheduler #(
  parameter int num_req_p  = 3,
  parameter int width_p    = 16,
  parameter int els_p      = 4,
  parameter int hi_to_lo_p = 0,
  localparam int tag_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  localparam int ctr_width_lp = $clog2(els_p)
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [num_req_p-1:0]               valid_i,
  input  logic [num_req_p*els_p*width_p-1:0] data_i,
  output logic [num_req_p-1:0]               ready_and_o,
  output logic                               valid_o,
  output logic [width_p-1:0]                 data_o,
  output logic [tag_width_lp-1:0]            tag_o,
  output logic                               last_o,
  input  logic                               yumi_i
`ifdef BSG_PISO_RR_SCHED_PERF_CTR_EN
  ,
  output logic [31:0]                        stall_cnt_o
`endif
);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e                                     state_q, state_d;
  logic [tag_width_lp-1:0]                    rrPtr_q, rrPtr_d;
  logic [tag_width_lp-1:0]                    tag_q, tag_d;
  logic [ctr_width_lp-1:0]                    shiftCtr_q, shiftCtr_d;
  logic [els_p-1:0][width_p-1:0]              word_q, word_d;
  logic [num_req_p-1:0][els_p-1:0][width_p-1:0] dataArr;
  logic [num_req_p-1:0]                       gnt;
  logic [tag_width_lp-1:0]                    gntId;
  logic                                       gntAny;
  logic                                       acceptWindow;
  logic                                       accept;
  logic [ctr_width_lp-1:0]                    elSel;

  assign dataArr = data_i;

  // First pass finds a requester at or above the pointer; second pass wraps around below it.
  always_comb begin
    gnt    = '0;
    gntId  = '0;
    gntAny = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      if (!gntAny && valid_i[i] && (i >= int'(rrPtr_q))) begin
        gnt[i] = 1'b1;
        gntId  = tag_width_lp'(i);
        gntAny = 1'b1;
      end
    end
    for (int i = 0; i < num_req_p; i++) begin
      if (!gntAny && valid_i[i]) begin
        gnt[i] = 1'b1;
        gntId  = tag_width_lp'(i);
        gntAny = 1'b1;
      end
    end
  end

  assign valid_o      = (state_q == SHIFT);
  assign last_o       = valid_o && (shiftCtr_q == ctr_width_lp'(els_p - 1));
  assign acceptWindow = (state_q == IDLE) || (last_o && yumi_i);
  assign ready_and_o  = gnt & {num_req_p{acceptWindow}};
  assign accept       = gntAny && acceptWindow;
  assign elSel        = (hi_to_lo_p != 0) ? (ctr_width_lp'(els_p - 1) - shiftCtr_q) : shiftCtr_q;
  assign data_o       = valid_o ? word_q[elSel] : '0;
  assign tag_o        = tag_q;

  always_comb begin
    state_d    = state_q;
    rrPtr_d    = rrPtr_q;
    tag_d      = tag_q;
    shiftCtr_d = shiftCtr_q;
    word_d     = word_q;
    case (state_q)
      IDLE: begin
      end
      SHIFT: begin
        if (yumi_i) begin
          if (!last_o) begin
            shiftCtr_d = shiftCtr_q + ctr_width_lp'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A reload on the final beat overrides the return to IDLE so words run back to back.
    if (accept) begin
      state_d    = SHIFT;
      word_d     = dataArr[gntId];
      tag_d      = gntId;
      shiftCtr_d = '0;
      rrPtr_d    = (gntId == tag_width_lp'(num_req_p - 1)) ? '0 : (gntId + tag_width_lp'(1));
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      rrPtr_q    <= '0;
      tag_q      <= '0;
      shiftCtr_q <= '0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      rrPtr_q    <= rrPtr_d;
      tag_q      <= tag_d;
      shiftCtr_q <= shiftCtr_d;
      word_q     <= word_d;
    end
  end

`ifdef BSG_PISO_RR_SCHED_PERF_CTR_EN
  logic [31:0] stallCnt_q, stallCnt_d;

  always_comb begin
    stallCnt_d = stallCnt_q;
    if (valid_o && !yumi_i && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stallCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
    end
  end

  assign stall_cnt_o = stallCnt_q;
`endif

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> valid_o);
  assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(ready_and_o));
`endif

endmodule
